score_bank_bcd: RTL and testbench
=================================

// Module: score_bank_bcd
// PURPOSE
//  Parametrised successor to the 2-digit score display: NUM_DIGITS-digit BCD score with
//  variable per-event increment, saturation, session high-score register, leading-zero
//  blanking and a blink flag for a new high score. Sits between the game FSM
//  (score events, round restart) and the board HEX displays.
// PARAMETERS
//  NUM_DIGITS  4         BCD digits in score and high score (2..8)
//  BLINK_DIV   25000000  clk cycles per blink half-period (>=1)
// PORTS
//  clk         in   1              system clock; all logic on rising edge
//  reset       in   1              synchronous, active-high; clears score AND high score
//  round_clr   in   1              1-cycle pulse: clear score only; high score kept
//  score_inc   in   1              1-cycle pulse: add inc_amt to score
//  inc_amt     in   4              BCD amount to add, 0..9; values 10..15 are treated as 0
//  show_high   in   1              0: display score; 1: display high score
//  blank_lz    in   1              1: blank leading zero digits
//  score_bcd   out  4*NUM_DIGITS   current score, digit 0 in [3:0]
//  high_bcd    out  4*NUM_DIGITS   high score, same packing
//  new_high    out  1              sticky: this round beat the previous high score
//  saturated   out  1              score is all 9s
//  hex_out     out  7*NUM_DIGITS   segments {g,f,e,d,c,b,a} per digit, 0 = segment lit
// BEHAVIOUR
//  - reset (sync, high): score=0, high=0, new_high=0, blink phase=0, blink counter=0.
//    Resulting outputs the cycle after reset: saturated=0, hex_out = "0" rightmost digit;
//    other digits blank if blank_lz=1, else "0".
//  - Priority each cycle: reset > round_clr > score_inc.
//  - round_clr: score<=0, new_high<=0 next cycle; high unchanged; a same-cycle score_inc is dropped.
//  - score_inc: score <= score + inc_amt (BCD ripple carry across all digits),
//    visible on score_bcd 1 cycle after the pulse. Back-to-back pulses are each counted.
//  - Saturation: if the true sum exceeds all-9s, score <= all-9s (no wrap).
//    saturated = (score == all-9s), combinational from the score register.
//  - inc_amt=0 or inc_amt>=10 with score_inc: score unchanged.
//  - High score: compare score vs high digit-wise from the MS digit (numeric compare).
//    If score > high: high <= score on the next clk, and new_high <= 1.
//    High therefore lags score by exactly 1 cycle. high is never decremented except by reset.
//    Ties do not set new_high.
//  - Blink: counter runs while new_high=1; toggles phase every BLINK_DIV cycles.
//    Counter and phase are held at 0 while new_high=0.
//    With show_high=0, new_high=1 and phase=1, every digit of hex_out = 7'h7F.
//    With show_high=1, no blinking.
//  - Display: selected value (score or high) decoded per digit with the 0-9 decoder.
//    blank_lz=1 blanks (7'h7F) every zero digit above the most-significant nonzero digit.
//    Digit 0 is always shown. hex_out is combinational from registers (no extra latency).
// STRUCTURE
//  - Shared package: SEG_BLANK=7'h7F, SEG_W=7, BCD_MAX=4'd9, digit-packing helper macros.
//  - Sub-module bcd_digit_add (a[3:0], b[3:0], cin -> sum[3:0], cout), chained NUM_DIGITS times.
//    Saturation is detected from the final cout.
//  - Existing hex7 decoder instantiated once per digit via generate.
//  - Registers: score, high, new_high, blink counter ($clog2(BLINK_DIV+1) bits), phase.
// TESTING  (NUM_DIGITS=4, BLINK_DIV=4 unless stated)
//  1. reset; 3x score_inc inc_amt=7 -> score_bcd 0x0007, 0x0014, 0x0021 on successive cycles;
//     high_bcd follows 1 cycle later; new_high=1.
//  2. score=0x9995, score_inc inc_amt=9 -> score 0x9999, saturated=1; another inc -> stays 0x9999.
//  3. high=0x0050, round_clr, then incs to 0x0050 -> new_high=0, high 0x0050;
//     +1 -> score 0x0051, then high 0x0051 and new_high=1.
//  4. round_clr and score_inc same cycle at score 0x0012 -> score 0x0000; reset mid-blink ->
//     high 0, new_high 0, phase 0.
//  5. score 0x0305, blank_lz=1 -> digit3 7'h7F, digit2 "3", digit1 "0", digit0 "5";
//     score 0 -> only digit0 "0" lit.
//  6. new_high=1, show_high=0 -> hex_out all 7'h7F for 4 cycles, digits for 4 cycles, repeating;
//     show_high=1 -> steady high score; inc_amt=12 with score_inc -> score unchanged.

Source files
------------

// File: rtl/score_bank_bcd_pkg.sv
// Shared constants and helpers for the BCD score bank: segment encoding widths,
// blank pattern and increment sanitising.
package score_bank_bcd_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0]   SEG_BLANK = 7'h7F;
    localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;

    // Increment values outside 0..9 are not valid BCD and count as zero.
    function automatic logic [DIGIT_W-1:0] sanitize_amt(input logic [DIGIT_W-1:0] amt);
        return (amt > BCD_MAX) ? '0 : amt;
    endfunction

endpackage

// File: rtl/hex7.sv
// Seven-segment decoder for one BCD digit, segments {g,f,e,d,c,b,a}, active-low.
module hex7 (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (digit_i)
            4'd0:    seg_o = 7'h40;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/score_bank_bcd_digit_add.sv
// Single BCD digit adder with decimal carry; chained to form a multi-digit ripple adder.
module bcd_digit_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
        adj = raw + 5'd6;
        if (raw > 5'd9) begin
            sum_o  = adj[3:0];
            cout_o = 1'b1;
        end else begin
            sum_o  = raw[3:0];
            cout_o = 1'b0;
        end
    end

endmodule

// File: rtl/score_bank_bcd.sv
// Multi-digit BCD score with saturation, session high score, leading-zero blanking
// and a blink indication while the current round holds a new high score.
module score_bank_bcd
    import score_bank_bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        round_clr_i,
    input  logic                        score_inc_i,
    input  logic [3:0]                  inc_amt_i,
    input  logic                        show_high_i,
    input  logic                        blank_lz_i,
    output logic [4*NUM_DIGITS-1:0]     score_bcd_o,
    output logic [4*NUM_DIGITS-1:0]     high_bcd_o,
    output logic                        new_high_o,
    output logic                        saturated_o,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out_o
);

    localparam int unsigned W     = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BLINK_DIV + 1);
    localparam logic [W-1:0]     ALL_NINES = {NUM_DIGITS{BCD_MAX}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);

    logic [W-1:0]            score_q, score_d, high_q, high_d;
    logic                    new_high_q, new_high_d, phase_q, phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]            addend, sum;
    logic [NUM_DIGITS:0]     carry;
    logic [W-1:0]            sel;
    logic [NUM_DIGITS-1:0]   blank;
    logic [SEG_W*NUM_DIGITS-1:0] seg;
    logic                    blink_off, above_msd;

    assign addend   = {{(W-4){1'b0}}, sanitize_amt(inc_amt_i)};
    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_add u_add (
            .a_i    (score_q[4*g +: 4]),
            .b_i    (addend[4*g +: 4]),
            .cin_i  (carry[g]),
            .sum_o  (sum[4*g +: 4]),
            .cout_o (carry[g+1])
        );

        hex7 u_hex (
            .digit_i (sel[4*g +: 4]),
            .seg_o   (seg[SEG_W*g +: SEG_W])
        );

        assign hex_out_o[SEG_W*g +: SEG_W] = blank[g] ? SEG_BLANK : seg[SEG_W*g +: SEG_W];
    end

    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        // Packed BCD orders the same as its numeric value, so a plain compare suffices.
        if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
        if (round_clr_i) begin
            score_d    = '0;
            new_high_d = 1'b0;
        end else if (score_inc_i) begin
            score_d = carry[NUM_DIGITS] ? ALL_NINES : sum;
        end

        // Blink timing restarts from zero each time new_high rises.
        if (!new_high_q || !new_high_d) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        sel       = show_high_i ? high_q : score_q;
        blink_off = new_high_q & phase_q & ~show_high_i;
        above_msd = 1'b1;
        blank     = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            above_msd = above_msd & (sel[4*i +: 4] == 4'd0);
            blank[i]  = blink_off | (blank_lz_i & above_msd & (i != 0));
        end
    end

    assign score_bcd_o = score_q;
    assign high_bcd_o  = high_q;
    assign new_high_o  = new_high_q;
    assign saturated_o = (score_q == ALL_NINES);

endmodule

// File: tb/tb_score_bank_bcd.sv
// Self-checking bench for score_bank_bcd: directed vector table, corner sequences and
// randomized traffic checked against an integer-arithmetic reference model.
module tb_score_bank_bcd;

    localparam int unsigned ND  = 4;
    localparam int unsigned DIV = 4;
    localparam int          MAXV = 9999;

    logic        clk_i = 1'b0;
    logic        reset_i, round_clr_i, score_inc_i, show_high_i, blank_lz_i;
    logic [3:0]  inc_amt_i;
    logic [15:0] score_bcd_o, high_bcd_o;
    logic        new_high_o, saturated_o;
    logic [27:0] hex_out_o;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain decimal integers plus elapsed blink cycles.
    int m_score = 0, m_high = 0, m_bc = 0;
    bit m_nh = 0;

    score_bank_bcd #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .round_clr_i (round_clr_i),
        .score_inc_i (score_inc_i),
        .inc_amt_i   (inc_amt_i),
        .show_high_i (show_high_i),
        .blank_lz_i  (blank_lz_i),
        .score_bcd_o (score_bcd_o),
        .high_bcd_o  (high_bcd_o),
        .new_high_o  (new_high_o),
        .saturated_o (saturated_o),
        .hex_out_o   (hex_out_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_hex(input int v, input logic sh, input logic lz);
        logic [27:0] r;
        int p = 1;
        bit off = m_nh && !sh && (((m_bc / DIV) % 2) == 1);
        for (int i = 0; i < 4; i++) begin
            if (off || (lz && i > 0 && v < p)) r[7*i +: 7] = 7'h7F;
            else r[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, clr, inc, input logic [3:0] amt);
        int s = m_score, h = m_high;
        bit nh = m_nh;
        int a;
        if (rst) begin
            m_score = 0; m_high = 0; m_nh = 0; m_bc = 0;
            return;
        end
        if (m_score > m_high) begin h = m_score; nh = 1; end
        if (clr) begin
            s = 0; nh = 0;
        end else if (inc) begin
            a = (amt < 10) ? int'(amt) : 0;
            s = (m_score + a > MAXV) ? MAXV : m_score + a;
        end
        m_bc = (m_nh && nh) ? m_bc + 1 : 0;
        m_score = s; m_high = h; m_nh = nh;
    endtask

    task automatic model_check();
        check("score", 64'(score_bcd_o), 64'(to_bcd(m_score)));
        check("high", 64'(high_bcd_o), 64'(to_bcd(m_high)));
        check("new_high", 64'(new_high_o), 64'(m_nh));
        check("saturated", 64'(saturated_o), 64'(m_score == MAXV));
        check("hex", 64'(hex_out_o), 64'(exp_hex(show_high_i ? m_high : m_score,
                                                 show_high_i, blank_lz_i)));
    endtask

    task automatic step(input logic rst, clr, inc, input logic [3:0] amt,
                        input logic sh, lz);
        reset_i = rst; round_clr_i = clr; score_inc_i = inc; inc_amt_i = amt;
        show_high_i = sh; blank_lz_i = lz;
        @(posedge clk_i);
        model_edge(rst, clr, inc, amt);
        #1;
        model_check();
    endtask

    typedef struct packed {
        logic        rst, clr, inc;
        logic [3:0]  amt;
        logic [15:0] s, h;
        logic        nh;
    } vec_t;

    vec_t vecs [15];
    logic [27:0] digits_one;

    initial begin
        vecs[0]  = '{1, 0, 0, 4'd0,  16'h0000, 16'h0000, 0};
        vecs[1]  = '{0, 0, 1, 4'd7,  16'h0007, 16'h0000, 0};
        vecs[2]  = '{0, 0, 1, 4'd7,  16'h0014, 16'h0007, 1};
        vecs[3]  = '{0, 0, 1, 4'd7,  16'h0021, 16'h0014, 1};
        vecs[4]  = '{0, 0, 0, 4'd0,  16'h0021, 16'h0021, 1};
        vecs[5]  = '{0, 1, 0, 4'd0,  16'h0000, 16'h0021, 0};
        vecs[6]  = '{0, 0, 1, 4'd9,  16'h0009, 16'h0021, 0};
        vecs[7]  = '{0, 0, 1, 4'd9,  16'h0018, 16'h0021, 0};
        vecs[8]  = '{0, 0, 1, 4'd3,  16'h0021, 16'h0021, 0};
        vecs[9]  = '{0, 0, 0, 4'd0,  16'h0021, 16'h0021, 0};
        vecs[10] = '{0, 0, 1, 4'd1,  16'h0022, 16'h0021, 0};
        vecs[11] = '{0, 0, 0, 4'd0,  16'h0022, 16'h0022, 1};
        vecs[12] = '{0, 0, 1, 4'd12, 16'h0022, 16'h0022, 1};
        vecs[13] = '{0, 1, 1, 4'd5,  16'h0000, 16'h0022, 0};
        vecs[14] = '{0, 0, 1, 4'd0,  16'h0000, 16'h0022, 0};

        reset_i = 1; round_clr_i = 0; score_inc_i = 0; inc_amt_i = 0;
        show_high_i = 0; blank_lz_i = 0;

        // Directed table: sequencing, lag of high, ties, invalid amounts, clear priority.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].inc, vecs[i].amt, 0, 0);
            check("vec_score", 64'(score_bcd_o), 64'(vecs[i].s));
            check("vec_high", 64'(high_bcd_o), 64'(vecs[i].h));
            check("vec_new_high", 64'(new_high_o), 64'(vecs[i].nh));
        end

        // Reset output state with leading-zero blanking.
        step(1, 0, 0, 0, 0, 1);
        check("reset_hex_lz", 64'(hex_out_o), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        check("reset_sat", 64'(saturated_o), 64'(0));

        // Saturation at all nines.
        for (int i = 0; i < 1110; i++) step(0, 0, 1, 4'd9, 0, 0);
        step(0, 0, 1, 4'd5, 0, 0);
        check("sat_pre", 64'(score_bcd_o), 64'(16'h9995));
        step(0, 0, 1, 4'd9, 0, 0);
        check("sat_hit", 64'(score_bcd_o), 64'(16'h9999));
        check("sat_flag", 64'(saturated_o), 64'(1));
        step(0, 0, 1, 4'd9, 0, 0);
        check("sat_hold", 64'(score_bcd_o), 64'(16'h9999));

        // Leading-zero blanking of 0305, shown via the (non-blinking) high score.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) step(0, 0, 1, 4'd9, 0, 0);
        step(0, 0, 1, 4'd8, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("lz_0305", 64'(hex_out_o), 64'({7'h7F, 7'h30, 7'h40, 7'h12}));

        // Blink cadence: 4 cycles lit, 4 blank, repeating.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        digits_one = {7'h40, 7'h40, 7'h40, 7'h79};
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step(0, 0, 0, 0, 0, 0);
            check("blink", 64'(hex_out_o),
                  ((k / 4) % 2 == 1) ? 64'(28'hFFFFFFF) : 64'(digits_one));
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 1, 0);
            check("show_high_steady", 64'(hex_out_o), 64'(digits_one));
        end
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_blink_high", 64'(high_bcd_o), 64'(0));
        check("rst_blink_nh", 64'(new_high_o), 64'(0));
        check("rst_blink_hex", 64'(hex_out_o), 64'({7'h40, 7'h40, 7'h40, 7'h40}));

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            int r = int'($urandom_range(0, 999));
            step(r < 3, r >= 3 && r < 15, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
